// File: rtl/apb_timer_arbiter_if.sv
// apb_timer_arbiter_if: requester-side and slave-side APB signals
// for the timer arbiter, with arb/master/slave views.
interface apb_timer_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 16
);
  logic [N_REQ*ADDR_W-1:0] m_paddr;
  logic [N_REQ-1:0]        m_psel;
  logic [N_REQ-1:0]        m_penable;
  logic [N_REQ-1:0]        m_pwrite;
  logic [N_REQ*32-1:0]     m_pwdata;
  logic [31:0]             m_prdata;
  logic [N_REQ-1:0]        m_pready;
  logic [N_REQ-1:0]        m_pslverr;

  logic [ADDR_W-1:0]       s_paddr;
  logic                    s_psel;
  logic                    s_penable;
  logic                    s_pwrite;
  logic [31:0]             s_pwdata;
  logic [31:0]             s_prdata;
  logic                    s_pready;
  logic                    s_pslverr;

  modport arb (
    input  m_paddr, m_psel, m_penable, m_pwrite, m_pwdata,
    output m_prdata, m_pready, m_pslverr,
    output s_paddr, s_psel, s_penable, s_pwrite, s_pwdata,
    input  s_prdata, s_pready, s_pslverr
  );

  modport master (
    output m_paddr, m_psel, m_penable, m_pwrite, m_pwdata,
    input  m_prdata, m_pready, m_pslverr
  );

  modport slave (
    input  s_paddr, s_psel, s_penable, s_pwrite, s_pwdata,
    output s_prdata, s_pready, s_pslverr
  );
endinterface

// File: rtl/apb_timer_arbiter.sv
// apb_timer_arbiter: round-robin share of one APB timer/IPI slave.
// Optional ACCESS watchdog enabled by APB_ARB_TIMEOUT_EN.
module apb_timer_arbiter #(
  parameter int N_REQ          = 2,
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  apb_timer_arbiter_if.arb         bus,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     busy
);
  localparam int GW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n
    $error("apb_timer_arbiter: N_REQ must be 2..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_to
    $error("apb_timer_arbiter: TIMEOUT_CYCLES must be 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    GAP
  } state_t;

  state_t        state;
  logic [GW-1:0] rr_ptr;
  logic          psel_q;
  logic          pen_q;

  logic [GW-1:0] pick;
  logic          any_req;
  logic [GW:0]   sum;
  logic          own_psel;
  logic          own_pen;
  logic          done_ok;
  logic          done_to;

  // Scan downwards so the requester closest after rr_ptr is written last.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    sum     = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      sum = {1'b0, rr_ptr} + (GW+1)'(k);
      if (sum >= (GW+1)'(N_REQ)) begin
        sum = sum - (GW+1)'(N_REQ);
      end
      if (bus.m_psel[sum[GW-1:0]]) begin
        pick    = sum[GW-1:0];
        any_req = 1'b1;
      end
    end
  end

  assign own_psel = bus.m_psel[grant_idx];
  assign own_pen  = bus.m_penable[grant_idx];

  assign bus.s_psel    = psel_q;
  assign bus.s_penable = pen_q;

  assign bus.s_paddr = psel_q
    ? bus.m_paddr[grant_idx*ADDR_W +: ADDR_W]
    : '0;
  assign bus.s_pwrite = psel_q & bus.m_pwrite[grant_idx];
  assign bus.s_pwdata = psel_q
    ? bus.m_pwdata[grant_idx*32 +: 32]
    : '0;

  assign done_ok = (state == ACCESS) & bus.s_pready;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 255) ? 16 : 8;

  logic [CW-1:0] tcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (state == SETUP) begin
      tcnt <= '0;
    end else if (state == ACCESS && !bus.s_pready &&
                 tcnt != CW'(TIMEOUT_CYCLES)) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // A slave ready in the expiry cycle is still a normal completion.
  assign done_to = (state == ACCESS) & ~bus.s_pready &
                   (tcnt == CW'(TIMEOUT_CYCLES));
`else
  assign done_to = 1'b0;
`endif

  always_comb begin
    bus.m_pready  = '0;
    bus.m_pslverr = '0;
    bus.m_prdata  = '0;
    if (done_ok) begin
      bus.m_pready[grant_idx]  = own_psel & own_pen;
      bus.m_pslverr[grant_idx] = own_psel & own_pen & bus.s_pslverr;
      bus.m_prdata             = bus.s_prdata;
    end else if (done_to) begin
      bus.m_pready[grant_idx]  = 1'b1;
      bus.m_pslverr[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= GW'(N_REQ-1);
      grant_idx <= '0;
      psel_q    <= 1'b0;
      pen_q     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant_idx <= pick;
            rr_ptr    <= pick;
            psel_q    <= 1'b1;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          pen_q <= 1'b1;
          state <= ACCESS;
        end
        ACCESS: begin
          if (done_ok || done_to) begin
            psel_q <= 1'b0;
            pen_q  <= 1'b0;
            state  <= GAP;
          end
        end
        GAP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          psel_q <= 1'b0;
          pen_q  <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/apb_timer_arbiter.md
Name: apb_timer_arbiter

Overview:
- Round-robin arbiter that shares the single 32-bit APB timer/IPI slave between N_REQ APB requesters, such as per-hart peripheral ports and a debug port.
- Sequences each granted transfer through slave SETUP/ACCESS phases, inserts a mandatory idle gap after each completion, and routes the response back to the owner.
- Sits between the hart-side APB fabric and the machine timer.

Parameters:
- N_REQ, 2, number of APB requesters (2..8).
- ADDR_W, 16, APB address width.
- TIMEOUT_CYCLES, 255, ACCESS-phase cycles before forced error completion (used only with APB_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous reset, active-high.
- m_paddr  in  N_REQ*ADDR_W  requester addresses, requester i at slice [i*ADDR_W +: ADDR_W].
- m_psel  in  N_REQ  requester selects.
- m_penable  in  N_REQ  requester enables.
- m_pwrite  in  N_REQ  requester write flags.
- m_pwdata  in  N_REQ*32  requester write data.
- m_prdata  out  32  read data, broadcast to all requesters.
- m_pready  out  N_REQ  per-requester ready.
- m_pslverr  out  N_REQ  per-requester error.
- s_paddr  out  ADDR_W  slave address.
- s_psel  out  1  slave select.
- s_penable  out  1  slave enable.
- s_pwrite  out  1  slave write flag.
- s_pwdata  out  32  slave write data.
- s_prdata  in  32  slave read data.
- s_pready  in  1  slave ready.
- s_pslverr  in  1  slave error.
- grant_idx  out  $clog2(N_REQ) (min 1)  index of the current or last owner.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset value of every registered output is 0: s_psel, s_penable, m_pready, m_pslverr, busy, grant_idx.
- Reset sets state=IDLE and rr_ptr=N_REQ-1, so requester 0 wins first.
- Reset mid-transfer: the slave transfer is abandoned, no m_pready is issued, and the FSM restarts in IDLE.
- FSM states:
  - IDLE: if any m_psel is set, grant the first set bit searching from rr_ptr+1 modulo N_REQ; latch grant_idx; set rr_ptr=grant_idx; go to SETUP. Otherwise stay in IDLE.
  - SETUP: s_psel=1, s_penable=0. s_paddr, s_pwrite and s_pwdata are muxed from the granted requester. Go to ACCESS.
  - ACCESS: s_psel=1, s_penable=1. Hold until s_pready=1. In that same cycle, combinationally drive:
    - m_pready[g] = s_pready & m_penable[g];
    - m_pslverr[g] = s_pslverr & m_pready[g];
    - m_prdata = s_prdata.
    Then go to GAP.
  - GAP: s_psel=0 for exactly one cycle so the slave returns to idle. Go to IDLE.
- Latency: m_psel sampled in cycle 0 gives SETUP in 1, ACCESS from 2, and m_pready in the first cycle s_pready is high (cycle 3 for a 1-wait-state slave). The earliest next SETUP is 3 cycles after completion.
- m_pready for non-owners is always 0. Requesters see wait states until served and must hold all signals stable while m_psel is high.
- Simultaneous requests are served strictly round-robin; no requester waits more than N_REQ-1 grants.
- Requester drops m_psel mid-transfer (protocol violation): the slave transfer still completes, m_pready is suppressed, and the FSM goes through GAP normally.
- A new m_psel asserted during SETUP, ACCESS or GAP is not considered until IDLE.
- s_* address, write and data outputs are 0 whenever s_psel=0.

Optional Feature:
- Macro APB_ARB_TIMEOUT_EN.
  - Defined: an 8..16-bit counter clears on entering ACCESS and increments each ACCESS cycle without s_pready. When it reaches TIMEOUT_CYCLES, the arbiter drives m_pready[g]=1, m_pslverr[g]=1 and m_prdata=0 for one cycle, then goes to GAP. If s_pready and the timeout coincide, s_pready wins and is a normal completion.
  - Undefined: no counter; ACCESS waits indefinitely.

Test Plan:
- Single read: req0 reads 16'h0008 with the slave returning 32'h1234_5678 one cycle after ACCESS -> s_psel high cycles 1-3, m_pready[0] pulses in cycle 3 with m_prdata=32'h1234_5678, s_psel=0 in cycle 4.
- Simultaneous: req0 and req1 both write 16'h0010 after reset -> req0 granted first and req1 second, with one GAP cycle between s_psel windows; grant_idx reads 0 then 1.
- Fairness: req0 and req1 continuously requesting for 8 transfers -> grants alternate 0,1,0,1,...; m_pready never goes to a non-owner.
- Error pass-through: slave returns s_pslverr=1 for req1 -> m_pslverr[1]=1 only in the m_pready[1] cycle; m_pslverr[0] stays 0.
- Reset mid-ACCESS: assert rst while in ACCESS -> all outputs 0 at once; after release, req1 is still pending and gets served within 2 cycles.
- With APB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, slave never readies -> m_pready[0]=1 and m_pslverr[0]=1 after 4 ACCESS cycles, then GAP, then IDLE.
